// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite slave onto a byte-enabled register file with a write-notify pulse
module axi_lite_reg_slave #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int NREGS = 8,
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              wr_pulse,
    output logic [IW-1:0]     wr_idx
);
    localparam int SB = DATA_W / 8;
    localparam int SH = $clog2(SB);
    localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NREGS);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t wst;
    rstate_t rst;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SB-1:0] wstrb_q;
    logic [DATA_W-1:0] regs [NREGS];
    logic aw_hs, w_hs, ar_hs, w_ok, r_ok;
    logic [ADDR_W-1:0] w_idx, r_idx;

    assign aw_hs = awvalid & awready;
    assign w_hs = wvalid & wready;
    assign ar_hs = arvalid & arready;
    assign w_idx = awaddr_q >> SH;
    assign r_idx = araddr >> SH;
    assign w_ok = {1'b0, w_idx} < NR;
    assign r_ok = {1'b0, r_idx} < NR;

    // Write channel FSM: collects AW and W in any order, commits byte-enabled data, then holds B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst <= W_IDLE;
            awready <= 1'b0;
            wready <= 1'b0;
            bvalid <= 1'b0;
            bresp <= OKAY;
            wr_pulse <= 1'b0;
            wr_idx <= '0;
            awaddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            wr_pulse <= 1'b0;
            case (wst)
                W_IDLE: begin
                    awready <= !aw_hs;
                    wready <= !w_hs;
                    if (aw_hs) awaddr_q <= awaddr;
                    if (w_hs) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    wst <= (aw_hs && w_hs) ? W_COMMIT : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
                end
                W_HAVE_AW: begin
                    if (w_hs) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        wready <= 1'b0;
                        wst <= W_COMMIT;
                    end
                end
                W_HAVE_W: begin
                    if (aw_hs) begin
                        awaddr_q <= awaddr;
                        awready <= 1'b0;
                        wst <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    if (w_ok) begin
                        for (int b = 0; b < SB; b++)
                            if (wstrb_q[b]) regs[w_idx[IW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
                        wr_pulse <= 1'b1;
                        wr_idx <= w_idx[IW-1:0];
                    end
                    bvalid <= 1'b1;
                    bresp <= w_ok ? OKAY : SLVERR;
                    wst <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        awready <= 1'b1;
                        wready <= 1'b1;
                        wst <= W_IDLE;
                    end
                end
                default: wst <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: latches register contents on AR and holds R until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst <= R_IDLE;
            arready <= 1'b0;
            rvalid <= 1'b0;
            rdata <= '0;
            rresp <= OKAY;
        end else begin
            case (rst)
                R_IDLE: begin
                    arready <= !ar_hs;
                    if (ar_hs) begin
                        rdata <= r_ok ? regs[r_idx[IW-1:0]] : '0;
                        rresp <= r_ok ? OKAY : SLVERR;
                        rvalid <= 1'b1;
                        rst <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        arready <= 1'b1;
                        rst <= R_IDLE;
                    end
                end
                default: rst <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: directed scoreboard bench for the AXI4-Lite register slave
module tb_axi_lite_reg_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [7:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid, wr_pulse;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [2:0] wr_idx;

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [8];
    logic [1:0] bq [$];
    logic [33:0] rq [$];

    axi_lite_reg_slave #(.ADDR_W(8), .DATA_W(32), .NREGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .wr_pulse(wr_pulse), .wr_idx(wr_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {awready, wready, arready, bvalid, rvalid, wr_pulse, bresp, rresp, rdata, wr_idx};
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int awd, input int wd, input int bd, input string tag);
        bit ad = 0, wdn = 0, ha, hw, inr;
        int n = 0;
        logic [1:0] eb;
        inr = (a >> 2) < 8;
        bq.push_back(inr ? 2'b00 : 2'b10);
        if (inr) for (int b = 0; b < 4; b++) if (s[b]) mdl[a>>2][8*b +: 8] = d[8*b +: 8];
        while (!(ad && wdn) && n < 50) begin
            @(negedge clk);
            if (wdn && !ad) chk({tag, "_haveW_rdy"}, {awready, wready}, 2'b10);
            if (ad && !wdn) chk({tag, "_haveAW_rdy"}, {awready, wready}, 2'b01);
            awvalid = !ad && n >= awd;
            wvalid = !wdn && n >= wd;
            awaddr = a;
            wdata = d;
            wstrb = s;
            ha = awvalid && awready;
            hw = wvalid && wready;
            @(posedge clk);
            ad |= ha;
            wdn |= hw;
            n++;
        end
        @(negedge clk);
        awvalid = 0;
        wvalid = 0;
        chk({tag, "_hs_done"}, {62'd0, ad, wdn}, 64'd3);
        chk({tag, "_commit_bvalid"}, bvalid, 0);
        @(negedge clk);
        chk({tag, "_bvalid"}, bvalid, 1);
        eb = bq.pop_front();
        chk({tag, "_bresp"}, bresp, eb);
        chk({tag, "_pulse"}, wr_pulse, inr);
        if (inr) chk({tag, "_idx"}, wr_idx, a >> 2);
        for (int i = 0; i < bd; i++) begin
            @(negedge clk);
            chk({tag, "_bhold"}, {bvalid, bresp, awready, wready, wr_pulse}, {1'b1, eb, 3'b000});
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk({tag, "_bdone"}, {bvalid, awready, wready}, 3'b011);
    endtask

    task automatic rd(input logic [7:0] a, input int rdl, input string tag);
        bit hs = 0, inr;
        int n = 0;
        logic [33:0] e;
        inr = (a >> 2) < 8;
        rq.push_back(inr ? {2'b00, mdl[a>>2]} : {2'b10, 32'd0});
        while (!hs && n < 50) begin
            @(negedge clk);
            arvalid = 1;
            araddr = a;
            hs = arready;
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 0;
        chk({tag, "_ar_hs"}, hs, 1);
        chk({tag, "_rvalid"}, rvalid, 1);
        e = rq.pop_front();
        chk({tag, "_rdata"}, {rresp, rdata}, e);
        for (int i = 0; i < rdl; i++) begin
            @(negedge clk);
            chk({tag, "_rhold"}, {rvalid, rresp, rdata, arready}, {1'b1, e, 1'b0});
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        chk({tag, "_rdone"}, {rvalid, arready}, 2'b01);
    endtask

    initial begin
        logic [33:0] er;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_out(), 0);
        rst_n = 1;
        chk("pre_edge_outs", all_out(), 0);
        @(negedge clk);
        chk("ready_after_reset", {awready, wready, arready}, 3'b111);

        wr(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, "wr_both");
        rd(8'h04, 0, "rd_r1");
        wr(8'h08, 32'h12345678, 4'h3, 3, 0, 0, "wr_w_first");
        rd(8'h08, 2, "rd_r2");
        wr(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, "wr_oor");
        rd(8'h20, 0, "rd_oor");
        wr(8'h14, 32'hCAFEF00D, 4'hF, 0, 2, 5, "wr_aw_first_bstall");
        wr(8'h0C, 32'hAAAA5555, 4'hF, 0, 0, 0, "wr_r3");
        wr(8'h1D, 32'h11223344, 4'hA, 1, 1, 1, "wr_strb_a");
        wr(8'h18, 32'hFFFFFFFF, 4'h0, 0, 0, 0, "wr_strb0");

        @(negedge clk);
        awvalid = 1; wvalid = 1; awaddr = 8'h0C; wdata = 32'h0; wstrb = 4'hF;
        bq.push_back(2'b00);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("conc_arready", arready, 1);
        arvalid = 1; araddr = 8'h0C;
        rq.push_back({2'b00, mdl[3]});
        mdl[3] = 32'h0;
        @(negedge clk);
        arvalid = 0;
        chk("conc_valids", {bvalid, rvalid, wr_pulse}, 3'b111);
        chk("conc_bresp", bresp, bq.pop_front());
        er = rq.pop_front();
        chk("conc_rdata", {rresp, rdata}, er);
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        chk("conc_done", {bvalid, rvalid}, 2'b00);
        rd(8'h0C, 0, "rd_r3_after");

        @(negedge clk);
        awvalid = 1; awaddr = 8'h10;
        @(negedge clk);
        awvalid = 0;
        chk("mid_have_aw", {awready, wready}, 2'b01);
        #2 rst_n = 0;
        #1 chk("mid_reset_outs", all_out(), 0);
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("mid_ready", {awready, wready, arready, bvalid}, 4'b1110);
        wr(8'h10, 32'h0BADC0DE, 4'hF, 0, 0, 0, "wr_after_reset");
        for (int i = 0; i < 8; i++) rd(8'(i * 4), 0, "rd_sweep");
        chk("sb_empty", bq.size() + rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
